// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud-timing derivation.
// The receiver and the transmitter both import this package so the
// bit-period arithmetic is identical on both sides of a link.
package uart_pkg;

  // FSM state encoding (plain constants so legacy code can share it)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Clock cycles per bit; integer division truncates (234 at 27 MHz / 115200).
  function automatic int baud_clk(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Cycles from the start-bit edge to the start-bit centre.
  function automatic int half_clk(input int clk_freq, input int baud_rate);
    return baud_clk(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RST_VAL sets the value both flops take in reset, so the output
// starts at the line's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to resolve.
  // NOTE: non-blocking assignments make both flops sample their inputs on the
  // same edge; blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver. A falling edge on the synchronized line starts a
// frame; the start bit is re-checked at its centre to reject glitches,
// then eight data bits (LSB first) and the stop bit are sampled at bit
// centres. The FSM returns to IDLE at mid-stop so a following start bit
// with no idle gap is still caught.
module uart_recv #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int BAUD_CLK = baud_clk(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CLK = half_clk(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_CLK - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BAUD_CLK - 1);

  logic             rx_s;
  logic             rx_prev;
  logic             fall;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             half_hit;
  logic             bit_hit;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (uart_rx),
    .q    (rx_s)
  );

  // Previous line level for falling-edge detection; resets to idle-high so
  // reset release on an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_prev <= 1'b1;
    else       rx_prev <= rx_s;
  end

  assign fall     = rx_prev & ~rx_s;
  assign half_hit = (cnt == CNT_HALF_LAST);
  assign bit_hit  = (cnt == CNT_BIT_LAST);
  assign rx_busy  = (state != ST_IDLE);

  // Next-state decode.
  // NOTE: state_nxt is given a default before the case so every path assigns
  // it; without that default an uncovered path would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: if (half_hit) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_hit && (bit_cnt == 3'd7)) state_nxt = ST_STOP;
      ST_STOP:  if (bit_hit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Baud counter: cleared on every state change, held at zero in IDLE, and
  // wrapped at each data-bit centre so the next sample is one bit later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if ((state_nxt != state) || (state == ST_IDLE) ||
                 ((state == ST_DATA) && bit_hit)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data shift register (LSB arrives first) and bit counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == ST_START) begin
      bit_cnt <= '0;
    end else if ((state == ST_DATA) && bit_hit) begin
      shreg   <= {rx_s, shreg[7:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Stop-bit check: a high stop bit publishes the byte, a low one flags a
  // framing error and leaves the last good byte in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data      <= 8'h00;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      if ((state == ST_STOP) && bit_hit) begin
        if (rx_s) begin
          rx_data <= shreg;
          rx_done <= 1'b1;
        end else begin
          rx_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv. A behavioural serial sender drives
// frames at a chosen (possibly fractional) bit period; a monitor collects
// every rx_done byte and rx_frame_err pulse, and each test compares what
// was collected against the bytes and errors the frame rules predict.
module tb_uart_recv;
  timeunit 1ns;
  timeprecision 100ps;

  // Scaled-down clock so full 256-byte sweeps stay short: 10 cycles per bit.
  localparam int CLK_FREQ  = 1_152_000;
  localparam int BAUD_RATE = 115_200;
  localparam int BAUD_CLK  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLK  = BAUD_CLK / 2;
  localparam int LATENCY   = 2 + 1 + HALF_CLK + 9 * BAUD_CLK;

  logic       clk     = 1'b0;
  logic       rstn    = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_recv #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [7:0] got_q[$];
  int         err_pulses  = 0;
  int         long_pulses = 0;
  int         both_high   = 0;
  int         data_glitch = 0;
  int         fall_cyc    = 0;
  int         done_cyc    = -1;
  logic       prev_done   = 1'b0;
  logic       prev_err    = 1'b0;
  logic [7:0] last_data   = 8'h00;

  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(rx_data);
      done_cyc <= cyc;
    end
    if (rx_frame_err)              err_pulses  <= err_pulses + 1;
    if (rx_done && prev_done)      long_pulses <= long_pulses + 1;
    if (rx_frame_err && prev_err)  long_pulses <= long_pulses + 1;
    if (rx_done && rx_frame_err)   both_high   <= both_high + 1;
    if (rstn && !rx_done && (rx_data !== last_data)) data_glitch <= data_glitch + 1;
    prev_done <= rx_done;
    prev_err  <= rx_frame_err;
    last_data <= rx_data;
  end

  // Drive one 8N1 frame; per is the sender's bit period in clock cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input real per);
    logic [9:0] bits;
    int         total;
    bits  = {stop, b, 1'b0};
    total = int'(10.0 * per);
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      if (n == 0) fall_cyc = cyc;
      uart_rx = bits[int'($floor(real'(n) / per))];
    end
  endtask

  task automatic idle_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_rx = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    @(negedge clk) rstn = 1'b1;
    idle_line(3 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL release_no_done: got %0d pulses want 0", got_q.size()); end
    n_cmp++; if (err_pulses != 0) begin n_bad++; $display("FAIL release_no_err: got %0d want 0", err_pulses); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL release_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_single();
    int e0;
    int lat;
    got_q.delete();
    e0 = err_pulses;
    send_frame(8'hA5, 1'b1, real'(BAUD_CLK));
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL single_err: got %0d want %0d", err_pulses, e0); end
    n_cmp++; if (long_pulses != 0) begin n_bad++; $display("FAIL single_width: got %0d long pulses want 0", long_pulses); end
    lat = done_cyc - fall_cyc;
    n_cmp++; if (lat < LATENCY - 1 || lat > LATENCY + 1) begin n_bad++; $display("FAIL single_latency: got %0d want %0d+-1", lat, LATENCY); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int   e0;
    int   back;
    logic saw_busy;
    got_q.delete();
    e0       = err_pulses;
    back     = -1;
    saw_busy = 1'b0;
    @(negedge clk) uart_rx = 1'b0;
    for (int k = 1; k <= HALF_CLK + 3; k++) begin
      @(negedge clk);
      if (k == HALF_CLK - 2) uart_rx = 1'b1;
      if (rx_busy) saw_busy = 1'b1;
      else if (saw_busy && back < 0) back = k;
    end
    n_cmp++; if (saw_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_seen: busy got %b want 1", saw_busy); end
    n_cmp++; if (back < 0) begin n_bad++; $display("FAIL glitch_idle: busy still %b after %0d cycles want 0", rx_busy, HALF_CLK + 3); end
    idle_line(3 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_no_done: got %0d want 0", got_q.size()); end
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL glitch_no_err: got %0d want %0d", err_pulses, e0); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL glitch_data: got %h want a5", rx_data); end
  endtask

  task automatic test_frame_err();
    int e0;
    got_q.delete();
    e0 = err_pulses;
    send_frame(8'h3C, 1'b0, real'(BAUD_CLK));
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL ferr_count: got %0d want %0d", err_pulses, e0 + 1); end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL ferr_no_done: got %0d want 0", got_q.size()); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL ferr_data_kept: got %h want a5", rx_data); end
  endtask

  task automatic test_break();
    int e0;
    got_q.delete();
    e0 = err_pulses;
    send_frame(8'h3C, 1'b0, real'(BAUD_CLK));
    for (int i = 0; i < 4 * BAUD_CLK; i++) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL break_busy: got %b want 0", rx_busy); end
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL break_err: got %0d want %0d", err_pulses, e0 + 1); end
    idle_line(2 * BAUD_CLK);
    send_frame(8'h5A, 1'b1, real'(BAUD_CLK));
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL break_resume_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL break_resume_data: got %h want 5a", rx_data); end
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL break_resume_err: got %0d want %0d", err_pulses, e0 + 1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    got_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h55};
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, real'(BAUD_CLK));
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int   e0;
    logic busy_before;
    got_q.delete();
    e0          = err_pulses;
    busy_before = 1'b0;
    fork
      send_frame(8'h81, 1'b1, real'(BAUD_CLK));
      begin
        // Land the reset in data bit 7 (line high, no later falling edge).
        repeat (8 * BAUD_CLK + 2) @(negedge clk);
        busy_before = rx_busy;
        rstn = 1'b0;
        #1;
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", rx_busy); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", rx_data); end
        repeat (5) @(negedge clk);
        rstn = 1'b1;
      end
    join
    n_cmp++; if (busy_before !== 1'b1) begin n_bad++; $display("FAIL midrst_in_frame: busy got %b want 1", busy_before); end
    idle_line(3 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL midrst_aborted: got %0d pulses want 0", got_q.size()); end
    send_frame(8'h7E, 1'b1, real'(BAUD_CLK));
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL midrst_next_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (rx_data !== 8'h7E) begin n_bad++; $display("FAIL midrst_next_data: got %h want 7e", rx_data); end
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL midrst_err: got %0d want %0d", err_pulses, e0); end
  endtask

  // Random bytes, random stop-bit faults and random idle gaps.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       stop;
    int         e0;
    int         exp_err;
    got_q.delete();
    e0      = err_pulses;
    exp_err = 0;
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) exp_q.push_back(b);
      else      exp_err++;
      send_frame(b, stop, real'(BAUD_CLK));
      // After a low stop bit the line must go high before the next start edge.
      idle_line(stop ? $urandom_range(0, 3) : $urandom_range(2, 4));
    end
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (err_pulses - e0 != exp_err) begin n_bad++; $display("FAIL rand_errs: got %0d want %0d", err_pulses - e0, exp_err); end
  endtask

  // All 256 byte values, back-to-back, at a given sender rate error.
  task automatic test_loopback(input real pct);
    logic [7:0] exp_q[$];
    int         e0;
    int         mult;
    int         off;
    real        per;
    got_q.delete();
    e0   = err_pulses;
    per  = real'(BAUD_CLK) / (1.0 + pct / 100.0);
    mult = int'($urandom_range(0, 127)) * 2 + 1;
    off  = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) exp_q.push_back(8'((i * mult + off) % 256));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, per);
    idle_line(2 * BAUD_CLK);
    n_cmp++; if (got_q.size() != 256) begin n_bad++; $display("FAIL loop%0.0f_count: got %0d want 256", pct, got_q.size()); end
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL loop%0.0f_byte%0d: got %h want %h", pct, i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL loop%0.0f_errs: got %0d want 0", pct, err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_loopback(0.0);
    test_loopback(2.0);
    test_loopback(-2.0);
    n_cmp++; if (long_pulses != 0) begin n_bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_pulses); end
    n_cmp++; if (both_high != 0) begin n_bad++; $display("FAIL done_and_err: got %0d overlaps want 0", both_high); end
    n_cmp++; if (data_glitch != 0) begin n_bad++; $display("FAIL data_stable: got %0d changes want 0", data_glitch); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-time bound: the full sequence needs well under 95k cycles.
  initial begin
    #950_000;
    $display("FAIL watchdog: simulation still running at cycle %0d want finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uart_rx, input, 1, asynchronous serial line; idles high.
REQ-006 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-007 SHALL have port rx_done, output, 1, one-cycle pulse when rx_data has been updated.
REQ-008 SHALL have port rx_frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port rx_busy, output, 1, high in any state other than IDLE.

Function
REQ-010 SHALL use these constants: BAUD_CLK = CLK_FREQ/BAUD_RATE (integer division, 234 at defaults) and HALF_CLK = BAUD_CLK/2 (117).
REQ-011 SHALL pass uart_rx through a 2-FF synchronizer; all further logic SHALL use only the synchronized signal (rx_s).
REQ-012 SHALL register rx_s once more and detect a falling edge as previous=1 and current=0.
REQ-013 SHALL size the baud counter to $clog2(BAUD_CLK) bits and clear it on every state transition.
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-015 IDLE: SHALL move to START on a detected falling edge; otherwise stay in IDLE.
REQ-016 START: when the counter reaches HALF_CLK-1, SHALL sample rx_s; if 0, go to DATA; if 1, treat as a glitch and return to IDLE with no output pulse.
REQ-017 DATA: every BAUD_CLK cycles, at bit centre, SHALL sample rx_s into a shift register, LSB first; a 3-bit bit counter SHALL move to STOP after the 8th sample.
REQ-018 STOP: at the first bit-centre sample, SHALL return to IDLE in the same cycle.
REQ-019 STOP: if the sample is 1, SHALL load the shift register into rx_data and pulse rx_done for one cycle.
REQ-020 STOP: if the sample is 0, SHALL pulse rx_frame_err for one cycle and leave rx_data unchanged.
REQ-021 Returning to IDLE at mid-stop SHALL allow a start edge arriving immediately afterwards, so back-to-back frames with no idle gap are received.
REQ-022 After a framing error with the line held low (break), SHALL accept no new frame until rx_s returns high and then falls again; this follows from edge detection.
REQ-023 rx_done and rx_frame_err SHALL never both be high, and each SHALL stay high for exactly one cycle per frame.
REQ-024 Latency: rx_done SHALL assert 2 sync + 1 edge + HALF_CLK + 9*BAUD_CLK cycles (±1) after the start-bit falling edge on uart_rx.
REQ-025 rx_data SHALL remain stable between rx_done pulses.
REQ-026 SHALL tolerate baud mismatch of up to ±2% between sender and receiver.

Reset
REQ-027 On rstn low, SHALL immediately put the FSM in IDLE and clear the counters and shift register.
REQ-028 On rstn low, SHALL set rx_data=8'h00, rx_done=0, rx_frame_err=0 and rx_busy=0.
REQ-029 On rstn low, SHALL set the synchronizer and edge registers to 1 (line-idle), so no false start edge occurs at reset release.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse; reception SHALL resume at the next falling edge after release.

Structure
REQ-031 The FSM state encoding and the BAUD_CLK/HALF_CLK derivation SHALL live in shared package uart_pkg, which the transmitter also uses.
REQ-032 The 2-FF synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset value parameter RST_VAL=1).
REQ-033 Target size is 120–250 lines of RTL, with a single clock domain after the synchronizer.

Verification
REQ-034 Send 0xA5 at 115200 with 1 stop bit -> rx_data=0xA5, rx_done is high for exactly 1 cycle, rx_frame_err=0, rx_busy drops after the pulse.
REQ-035 Drive uart_rx low for 50 cycles, then high -> no rx_done, no rx_frame_err, FSM back in IDLE within HALF_CLK+3 cycles.
REQ-036 Send 0x3C with the stop bit forced to 0 -> rx_frame_err pulses once and rx_data keeps its previous value (e.g. 0xA5).
REQ-037 Send 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three rx_done pulses, with rx_data 0x00, 0xFF, 0x55 in order.
REQ-038 Assert rstn for 5 cycles mid-way through 0x81, then send 0x7E -> no pulse for 0x81; rx_data=0x7E with one rx_done.
REQ-039 Loop back from the team UART transmitter (same parameters) for all bytes 0x00–0xFF, and repeat with the sender at +2% and -2% baud -> all 256 bytes match and there are no frame errors.
